condicionador_botoes: RTL and testbench

//  Input stage feeding the S1 game datapath. Synchronises and debounces the 7 raw game buttons.

---
 rtl/condicionador_botoes.sv | 105 ++++++++++
 tb/tb_condicionador_botoes.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// Button input stage: 2-FF synchroniser, debounce FSM and one-hot press filter.
// Emits a registered one-hot jogada plus a single-cycle strobe per clean press.
module condicionador_botoes #(
  parameter int N_BOTOES        = 7,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CW              = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_raw,
  input  logic                habilita,
  input  logic                limpa,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                multipla,
  output logic                ocupado,
  output logic [1:0]          db_estado
);

  typedef enum logic [1:0] {
    OCIOSO       = 2'b00,
    FILTRA_PRESS = 2'b01,
    PRESSIONADO  = 2'b10,
    FILTRA_SOLTA = 2'b11
  } estado_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  estado_t             estado;
  logic [CW-1:0]       cnt;
  logic [N_BOTOES-1:0] sync1;
  logic [N_BOTOES-1:0] sinc;
  logic [N_BOTOES-1:0] candidato;
  logic                cand_um;

  // candidato is never zero while filtering, so the power-of-two test is enough.
  assign cand_um   = (candidato != '0) &&
                     ((candidato & (candidato - N_BOTOES'(1))) == '0);
  assign ocupado   = (estado != OCIOSO);
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      sync1        <= '0;
      sinc         <= '0;
      candidato    <= '0;
      jogada       <= '0;
      jogada_feita <= 1'b0;
      multipla     <= 1'b0;
    end else begin
      sync1        <= botoes_raw;
      sinc         <= sync1;
      jogada_feita <= 1'b0;
      multipla     <= 1'b0;
      // An accept later in this block overrides the clear.
      if (limpa) jogada <= '0;
      case (estado)
        OCIOSO: begin
          if (sinc != '0) begin
            estado    <= FILTRA_PRESS;
            candidato <= sinc;
            cnt       <= '0;
          end
        end
        FILTRA_PRESS: begin
          if (sinc == '0) begin
            estado <= OCIOSO;
          end else if (sinc != candidato) begin
            candidato <= sinc;
            cnt       <= '0;
          end else if (cnt == CNT_MAX) begin
            estado <= PRESSIONADO;
            if (cand_um && habilita) begin
              jogada       <= candidato;
              jogada_feita <= 1'b1;
            end else if (!cand_um) begin
              multipla <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSIONADO: begin
          if (sinc == '0) begin
            estado <= FILTRA_SOLTA;
            cnt    <= '0;
          end
        end
        FILTRA_SOLTA: begin
          if (sinc != '0) begin
            estado <= PRESSIONADO;
          end else if (cnt == CNT_MAX) begin
            estado <= OCIOSO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios plus random button traffic,
// each cycle compared against a run-length model of the debounce rules.
module tb_condicionador_botoes;

  localparam int N = 7;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] botoes_raw;
  logic         habilita;
  logic         limpa;
  logic [N-1:0] jogada;
  logic         jogada_feita;
  logic         multipla;
  logic         ocupado;
  logic [1:0]   db_estado;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  condicionador_botoes #(.N_BOTOES(N), .DEBOUNCE_CYCLES(D), .CW(4)) dut (
    .clock(clock), .reset(reset), .botoes_raw(botoes_raw), .habilita(habilita),
    .limpa(limpa), .jogada(jogada), .jogada_feita(jogada_feita),
    .multipla(multipla), .ocupado(ocupado), .db_estado(db_estado)
  );

  // Reference model: 2-sample delay line, then run lengths of stable patterns.
  logic [N-1:0] m_d1, m_d2, m_last, m_jog;
  logic         m_armed, m_feita, m_mult;
  int           m_run, m_zrun;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_last = '0; m_jog = '0;
    m_armed = 1'b1; m_feita = 1'b0; m_mult = 1'b0;
    m_run = 0; m_zrun = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw, input logic hab, lim, rst);
    logic [N-1:0] s;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    m_feita = 1'b0;
    m_mult = 1'b0;
    if (lim) m_jog = '0;
    if (m_armed) begin
      if (s == '0) m_run = 0;
      else if (m_run > 0 && s == m_last) m_run++;
      else begin m_last = s; m_run = 1; end
      if (m_run == D + 1) begin
        if ($countones(s) == 1 && hab) begin m_jog = s; m_feita = 1'b1; end
        else if ($countones(s) > 1) m_mult = 1'b1;
        m_armed = 1'b0; m_run = 0; m_zrun = 0;
      end
    end else begin
      if (s == '0) m_zrun++;
      else m_zrun = 0;
      if (m_zrun == D + 1) begin m_armed = 1'b1; m_zrun = 0; end
    end
  endtask

  function automatic logic [1:0] model_code();
    if (m_armed) return (m_run == 0) ? 2'b00 : 2'b01;
    return (m_zrun == 0) ? 2'b10 : 2'b11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] raw, input logic hab, lim, rst);
    botoes_raw = raw; habilita = hab; limpa = lim; reset = rst;
    @(posedge clock);
    model_edge(raw, hab, lim, rst);
    #1;
    chk("jogada", 32'(jogada), 32'(m_jog));
    chk("jogada_feita", 32'(jogada_feita), 32'(m_feita));
    chk("multipla", 32'(multipla), 32'(m_mult));
    chk("db_estado", 32'(db_estado), 32'(model_code()));
    chk("ocupado", 32'(ocupado), 32'(model_code() != 2'b00));
  endtask

  int feita_n, mult_n, first_pulse;

  task automatic hold(input logic [N-1:0] p, input int n, input logic hab);
    for (int i = 0; i < n; i++) begin
      step(p, hab, 1'b0, 1'b0);
      if (jogada_feita) begin
        feita_n++;
        if (first_pulse == 0) first_pulse = i + 1;
      end
      if (multipla) mult_n++;
    end
  endtask

  task automatic clr_counts();
    feita_n = 0; mult_n = 0; first_pulse = 0;
  endtask

  initial begin
    logic [N-1:0] pat;
    int len;
    logic hab;
    model_reset();
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    chk("reset_jogada", 32'(jogada), 32'h0);
    chk("reset_estado", 32'(db_estado), 32'h0);

    // 1: clean press, strobe on the 7th edge counting the first sampled one
    clr_counts();
    hold(7'b0000100, 20, 1'b1);
    chk("t1_strobes", 32'(feita_n), 32'd1);
    chk("t1_latency", 32'(first_pulse), 32'd7);
    chk("t1_jogada", 32'(jogada), 32'h04);
    hold('0, 10, 1'b1);
    chk("t1_idle", 32'(db_estado), 32'h0);

    // 2: bounce then hold
    clr_counts();
    hold(7'b0000100, 2, 1'b1);
    hold('0, 1, 1'b1);
    chk("t2_burst", 32'(feita_n), 32'd0);
    hold(7'b0000100, 20, 1'b1);
    chk("t2_strobes", 32'(feita_n), 32'd1);
    chk("t2_mult", 32'(mult_n), 32'd0);
    hold('0, 10, 1'b1);

    // 3: two buttons, then another pattern without release
    clr_counts();
    hold(7'b0010001, 20, 1'b1);
    chk("t3_mult", 32'(mult_n), 32'd1);
    chk("t3_feita", 32'(feita_n), 32'd0);
    chk("t3_jogada", 32'(jogada), 32'h04);
    clr_counts();
    hold(7'b0010010, 20, 1'b1);
    chk("t3_nopulse", 32'(mult_n + feita_n), 32'd0);
    hold('0, 10, 1'b1);

    // 4: muted press, then enabled press
    clr_counts();
    hold(7'b1000000, 20, 1'b0);
    chk("t4_muted", 32'(mult_n + feita_n), 32'd0);
    chk("t4_jogada", 32'(jogada), 32'h04);
    hold('0, 10, 1'b0);
    clr_counts();
    hold(7'b0000001, 20, 1'b1);
    chk("t4_strobes", 32'(feita_n), 32'd1);
    chk("t4_jogada2", 32'(jogada), 32'h01);
    hold('0, 10, 1'b1);

    // 5: limpa while held, then repress
    hold(7'b0000010, 12, 1'b1);
    step(7'b0000010, 1'b1, 1'b1, 1'b0);
    hold(7'b0000010, 3, 1'b1);
    chk("t5_cleared", 32'(jogada), 32'h0);
    hold('0, 10, 1'b1);
    clr_counts();
    hold(7'b0000010, 20, 1'b1);
    chk("t5_strobes", 32'(feita_n), 32'd1);
    chk("t5_jogada", 32'(jogada), 32'h02);
    hold('0, 10, 1'b1);

    // 6: reset mid-filter with the button still held
    hold(7'b0000100, 4, 1'b1);
    chk("t6_filtering", 32'(db_estado), 32'h1);
    step(7'b0000100, 1'b1, 1'b0, 1'b1);
    chk("t6_rst_jogada", 32'(jogada), 32'h0);
    chk("t6_rst_estado", 32'(db_estado), 32'h0);
    clr_counts();
    hold(7'b0000100, 12, 1'b1);
    chk("t6_strobes", 32'(feita_n), 32'd1);
    chk("t6_latency", 32'(first_pulse), 32'd7);
    hold('0, 10, 1'b1);

    // Random traffic: bursts of patterns, occasional limpa and reset
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: pat = '0;
        1, 2: pat = N'(1) << $urandom_range(0, N - 1);
        default: pat = N'($urandom_range(1, (1 << N) - 1));
      endcase
      len = $urandom_range(1, 9);
      hab = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++)
        step(pat, hab, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
